// File: rtl/nextsb_pkg.sv
// Shared constants for the NeXT Sound Box keyboard path: keycode FIFO sizing
// and the bit positions of its status fields inside the pio_1 controls word.
package nextsb_pkg;

    localparam int unsigned KC_W     = 16;
    localparam int unsigned KC_DEPTH = 8;

    // pio_1 controls word layout; firmware reads the same offsets
    localparam int unsigned PIO_KC_COUNT_LSB = 16;
    localparam int unsigned PIO_KC_COUNT_W   = $clog2(KC_DEPTH) + 1;
    localparam int unsigned PIO_KC_AVAIL_BIT = PIO_KC_COUNT_LSB + PIO_KC_COUNT_W;
    localparam int unsigned PIO_KC_OVF_BIT   = PIO_KC_AVAIL_BIT + 1;

endpackage

// File: rtl/keycode_fifo.sv
// Keycode event FIFO between the keyboard decoder and the CPU PIO: pushes on
// kc_valid, pops on each pop_toggle level change, sticky overflow on drops.
module keycode_fifo #(
    parameter int unsigned KC_W  = nextsb_pkg::KC_W,
    parameter int unsigned DEPTH = nextsb_pkg::KC_DEPTH
) (
    input  logic                       clk27,
    input  logic                       po_reset_n,
    input  logic [KC_W-1:0]            kc_in,
    input  logic                       kc_valid,
    input  logic                       pop_toggle,
    input  logic                       clear,
    output logic [KC_W-1:0]            kc_head,
    output logic [$clog2(DEPTH):0]     kc_count,
    output logic                       kc_avail,
    output logic                       kc_overflow
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;

    logic [KC_W-1:0] mem [DEPTH];
    logic [AW-1:0]   wr_ptr;
    logic [AW-1:0]   rd_ptr;
    logic [CW-1:0]   count;
    logic            ovf;
    logic            pop_prev;

    logic            pop_ev;
    logic            not_empty;
    logic            full;
    logic            pop_eff;
    logic            push_eff;

    always_comb begin
        pop_ev    = pop_toggle ^ pop_prev;
        not_empty = (count != '0);
        full      = (count == CW'(DEPTH));
        pop_eff   = pop_ev && not_empty;
        // a pop in the same cycle frees the slot, so a full FIFO still accepts
        push_eff  = kc_valid && (!full || pop_eff);
    end

    always_ff @(posedge clk27 or negedge po_reset_n) begin
        if (!po_reset_n) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            ovf      <= 1'b0;
            pop_prev <= 1'b0;
        end else begin
            pop_prev <= pop_toggle;
            if (clear) begin
                wr_ptr <= '0;
                rd_ptr <= '0;
                count  <= '0;
                ovf    <= 1'b0;
            end else begin
                if (push_eff) begin
                    wr_ptr <= wr_ptr + AW'(1);
                end
                if (pop_eff) begin
                    rd_ptr <= rd_ptr + AW'(1);
                end
                if (kc_valid && !push_eff) begin
                    ovf <= 1'b1;
                end
                case ({push_eff, pop_eff})
                    2'b10:   count <= count + CW'(1);
                    2'b01:   count <= count - CW'(1);
                    default: count <= count;
                endcase
            end
        end
    end

    // Storage is deliberately unreset; clear only rewinds the pointers
    always_ff @(posedge clk27) begin
        if (!clear && push_eff) begin
            mem[wr_ptr] <= kc_in;
        end
    end

    assign kc_head     = not_empty ? mem[rd_ptr] : '0;
    assign kc_count    = count;
    assign kc_avail    = not_empty;
    assign kc_overflow = ovf;

endmodule

// File: tb/tb_keycode_fifo.sv
// Directed self-checking bench for keycode_fifo: a vector table for the main
// push/pop/clear behaviour plus hand sequences for full swap, async reset and wrap.
module tb_keycode_fifo;

    logic        clk27;
    logic        po_reset_n;
    logic [15:0] kc_in;
    logic        kc_valid;
    logic        pop_toggle;
    logic        clear;
    logic [15:0] kc_head;
    logic [3:0]  kc_count;
    logic        kc_avail;
    logic        kc_overflow;

    int n_cmp;
    int n_bad;

    keycode_fifo #(.KC_W(16), .DEPTH(8)) dut (
        .clk27       (clk27),
        .po_reset_n  (po_reset_n),
        .kc_in       (kc_in),
        .kc_valid    (kc_valid),
        .pop_toggle  (pop_toggle),
        .clear       (clear),
        .kc_head     (kc_head),
        .kc_count    (kc_count),
        .kc_avail    (kc_avail),
        .kc_overflow (kc_overflow)
    );

    initial clk27 = 1'b0;
    always #5 clk27 = ~clk27;

    typedef struct {
        logic        valid;
        logic [15:0] data;
        logic        pop;
        logic        clr;
        logic [15:0] exp_head;
        logic [3:0]  exp_count;
        logic        exp_avail;
        logic        exp_ovf;
    } vec_t;

    vec_t vecs[$];

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    task automatic check_all(input string name, input logic [15:0] head, input logic [3:0] cnt,
                             input logic avail, input logic ovf);
        check({name, ".head"},  32'(kc_head),     32'(head));
        check({name, ".count"}, 32'(kc_count),    32'(cnt));
        check({name, ".avail"}, 32'(kc_avail),    32'(avail));
        check({name, ".ovf"},   32'(kc_overflow), 32'(ovf));
    endtask

    // Drive one cycle of inputs, let the edge happen, return 1 time unit after it
    task automatic drive(input logic v, input logic [15:0] d, input logic p, input logic c);
        kc_valid = v;
        kc_in    = d;
        clear    = c;
        if (p) pop_toggle = ~pop_toggle;
        @(posedge clk27);
        #1;
        kc_valid = 1'b0;
        clear    = 1'b0;
    endtask

    task automatic add(input logic v, input logic [15:0] d, input logic p, input logic c,
                       input logic [15:0] h, input logic [3:0] n, input logic a, input logic o);
        vec_t t;
        t.valid = v; t.data = d; t.pop = p; t.clr = c;
        t.exp_head = h; t.exp_count = n; t.exp_avail = a; t.exp_ovf = o;
        vecs.push_back(t);
    endtask

    logic [15:0] model_q[$];

    initial begin
        n_cmp      = 0;
        n_bad      = 0;
        po_reset_n = 1'b0;
        kc_in      = '0;
        kc_valid   = 1'b0;
        pop_toggle = 1'b0;
        clear      = 1'b0;

        //  v  data      pop clr  head      cnt avail ovf
        add(1, 16'h1A2B, 0, 0,  16'h1A2B, 1, 1, 0);
        add(0, 16'h0000, 1, 0,  16'h0000, 0, 0, 0);
        add(0, 16'h0000, 1, 0,  16'h0000, 0, 0, 0);   // pop on empty ignored
        for (int i = 1; i <= 8; i++)
            add(1, 16'(i), 0, 0, 16'h0001, 4'(i), 1, 0);
        add(1, 16'h0009, 0, 0,  16'h0001, 8, 1, 1);   // dropped push
        add(1, 16'h00AA, 1, 0,  16'h0002, 8, 1, 1);   // swap at full, ovf sticky
        for (int i = 3; i <= 8; i++)
            add(0, 16'h0000, 1, 0, 16'(i), 4'(10 - i), 1, 1);
        add(0, 16'h0000, 1, 0,  16'h00AA, 1, 1, 1);
        add(0, 16'h0000, 1, 0,  16'h0000, 0, 0, 1);
        add(1, 16'h0055, 1, 0,  16'h0055, 1, 1, 1);   // push+pop on empty
        add(1, 16'h1234, 0, 1,  16'h0000, 0, 0, 0);   // clear beats push and ovf
        add(1, 16'h0000, 0, 0,  16'h0000, 1, 1, 0);   // zero keycode still stored
        add(0, 16'h0000, 0, 1,  16'h0000, 0, 0, 0);

        #12;
        check_all("reset", 16'h0000, 0, 0, 0);
        @(negedge clk27);
        po_reset_n = 1'b1;
        @(posedge clk27);
        #1;

        for (int i = 0; i < vecs.size(); i++) begin
            drive(vecs[i].valid, vecs[i].data, vecs[i].pop, vecs[i].clr);
            check_all($sformatf("vec%0d", i), vecs[i].exp_head, vecs[i].exp_count,
                      vecs[i].exp_avail, vecs[i].exp_ovf);
        end

        // Full swap with overflow clear: oldest leaves, 00AA lands at the tail
        for (int i = 1; i <= 8; i++) drive(1, 16'(i), 0, 0);
        drive(1, 16'h00AA, 1, 0);
        check_all("swap_full", 16'h0002, 8, 1, 0);
        for (int i = 0; i < 7; i++) drive(0, 16'h0000, 1, 0);
        check_all("swap_tail", 16'h00AA, 1, 1, 0);
        drive(0, 16'h0000, 1, 0);

        // Overflow with three entries, then clear with a simultaneous push
        for (int i = 0; i < 8; i++) drive(1, 16'h0100 + 16'(i), 0, 0);
        drive(1, 16'h01FF, 0, 0);
        for (int i = 0; i < 5; i++) drive(0, 16'h0000, 1, 0);
        check_all("pre_clear", 16'h0105, 3, 1, 1);
        drive(1, 16'hDEAD, 0, 1);
        check_all("clear", 16'h0000, 0, 0, 0);
        drive(1, 16'h0777, 0, 0);
        check_all("post_clear", 16'h0777, 1, 1, 0);
        drive(0, 16'h0000, 1, 0);

        // Asynchronous reset mid-cycle with five entries stored
        for (int i = 0; i < 5; i++) drive(1, 16'h0200 + 16'(i), 0, 0);
        check_all("pre_reset", 16'h0200, 5, 1, 0);
        #2;
        po_reset_n = 1'b0;
        #1;
        check_all("async_reset", 16'h0000, 0, 0, 0);
        pop_toggle = 1'b1;   // pop event at release lands on an empty FIFO
        @(negedge clk27);
        po_reset_n = 1'b1;

        // Ordering across pointer wrap-around with a small model queue
        for (int i = 0; i < 3; i++) begin
            drive(1, 16'hC000 + 16'(i), 0, 0);
            model_q.push_back(16'hC000 + 16'(i));
        end
        check_all("wrap_fill", 16'hC000, 3, 1, 0);
        for (int i = 3; i < 23; i++) begin
            drive(1, 16'hC000 + 16'(i), 1, 0);
            void'(model_q.pop_front());
            model_q.push_back(16'hC000 + 16'(i));
            check($sformatf("wrap%0d.head", i), 32'(kc_head), 32'(model_q[0]));
        end
        check("wrap.count", 32'(kc_count), 32'(model_q.size()));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/keycode_fifo.md
# keycode_fifo

Event buffer between the NeXT Sound Box keyboard decoder and the CPU control PIO. It captures every keycode strobe in a small FIFO, so that presses arriving faster than firmware polling are not overwritten. It presents the oldest entry, the fill level and a sticky overflow flag on the `pio_1` controls input. Firmware pops one entry per toggle of a `sys_ctrl` bit.

## Interface
Parameters:
- `KC_W`, 16, keycode width in bits.
- `DEPTH`, 8, number of FIFO entries; must be a power of two, minimum 2.

Ports:
- `clk27`  in  1  system clock, shared with the CPU and the NeXT Sound Box logic.
- `po_reset_n`  in  1  asynchronous active-low reset.
- `kc_in`  in  KC_W  keycode from the decoder; sampled only when `kc_valid`=1.
- `kc_valid`  in  1  single-cycle push strobe, already in the `clk27` domain.
- `pop_toggle`  in  1  CPU pop request; every change of level is one pop.
- `clear`  in  1  level-sensitive synchronous flush.
- `kc_head`  out  KC_W  oldest entry; 0 when the FIFO is empty.
- `kc_count`  out  $clog2(DEPTH)+1  number of stored entries, range 0..DEPTH.
- `kc_avail`  out  1  high when `kc_count` != 0.
- `kc_overflow`  out  1  sticky; set when a push is dropped.

## Operation
- State:
  - Storage array `mem[DEPTH]`.
  - `wr_ptr` and `rd_ptr`, each $clog2(DEPTH) bits, wrapping modulo DEPTH.
  - `count`, `ovf`, `pop_prev`.
- Pop event: `pop_ev = pop_toggle ^ pop_prev`. `pop_prev` follows `pop_toggle` every cycle, including cycles where `clear` is high.
- Effective pop: `pop_ev && count != 0`. A pop on an empty FIFO is discarded with no side effects.
- Effective push: `kc_valid && (count != DEPTH || pop_eff)`. It writes `mem[wr_ptr] <= kc_in` and increments `wr_ptr`.
- Dropped push: `kc_valid` while full and no effective pop in the same cycle. The store is unchanged and `ovf` is set.
- Count update:
  - +1 for a push alone.
  - −1 for a pop alone.
  - Unchanged for a simultaneous push and pop, including at full: the oldest entry leaves, the new one enters, and the count stays at DEPTH.
- Empty FIFO with push and pop in the same cycle: the pop is discarded, the push proceeds, and `count` becomes 1.
- `clear` = 1 has priority over push, pop and overflow:
  - `wr_ptr`, `rd_ptr`, `count` and `ovf` go to 0.
  - A `kc_valid` in the same cycle is lost and does not set `ovf`.
  - `mem` contents are not cleared.
- `ovf` is cleared only by `clear` or reset.
- Outputs:
  - `kc_head = (count != 0) ? mem[rd_ptr] : 0`, read combinationally from registered state.
  - `kc_count = count`.
  - `kc_avail = (count != 0)`.
  - `kc_overflow = ovf`.
- Keycode values, including 16'h0000, are stored without filtering. Firmware uses `kc_avail` rather than a zero test.

## Timing
- Reset values: `wr_ptr`, `rd_ptr`, `count`, `ovf` and `pop_prev` are 0. Outputs therefore reset to `kc_head`=0, `kc_count`=0, `kc_avail`=0, `kc_overflow`=0. `mem` is not reset.
- Asserting `po_reset_n` low mid-operation empties the FIFO immediately (asynchronous). The first event is sampled on the first rising edge after release.
- If `pop_toggle`=1 at reset release, the first edge produces a pop event. The FIFO is empty at that point, so the event is harmless.
- Push latency: `kc_valid` sampled at edge N makes `kc_count`, `kc_avail` and, when the FIFO was empty, `kc_head` reflect the push after edge N.
- Pop latency: a toggle sampled at edge N advances `kc_head` and `kc_count` after edge N.
- Back-to-back `kc_valid` on consecutive cycles is supported with one entry stored per cycle.
- Back-to-back pops need one toggle per cycle. The CPU PIO write rate guarantees that toggles are at least one cycle apart.
- Only registered state feeds the outputs; there is no combinational path from inputs to outputs.
- No CDC: all inputs are in the `clk27` domain. The top level adds no further synchronizer stages.

## Structure
- A shared `nextsb_pkg` header holds `KC_W`=16, `KC_DEPTH`=8, and the PIO bit-field offsets for `kc_count`, `kc_avail` and `kc_overflow` within the `pio_1` controls word, so the RTL and firmware agree.
- Single module with no sub-module. Storage is a register array (DEPTH × KC_W = 128 flops), because it is too small to justify a RAM macro.

## Test plan
- Reset, then push 16'h1A2B → after the next edge: `kc_head`=16'h1A2B, `kc_count`=1, `kc_avail`=1.
- Push 16'h0001..16'h0008 on consecutive cycles, then push 16'h0009 → `kc_count`=8, `kc_overflow`=1, `kc_head`=16'h0001. Eight toggles then read 16'h0001..16'h0008 in order, after which `kc_count`=0 and `kc_head`=0.
- FIFO full (16'h0001..16'h0008), push 16'h00AA and toggle in the same cycle → `kc_count`=8, `kc_overflow`=0, `kc_head`=16'h0002, last entry 16'h00AA.
- Empty FIFO, push 16'h0055 and toggle in the same cycle → `kc_count`=1, `kc_head`=16'h0055.
- Three entries stored with `ovf`=1, then `clear` for one cycle with `kc_valid` high → `kc_count`=0, `kc_overflow`=0, `kc_avail`=0. A push afterwards lands as the sole entry, exercising pointer wrap after the flush.
- Five entries stored, `po_reset_n` pulsed low mid-cycle → outputs return to 0 without a clock edge. Afterwards, 20 push/pop pairs confirm correct ordering across pointer wrap-around.
